// File: rtl/debounce_array.sv
// Multi-channel button/switch debouncer: 2-flop sync, optional inversion, debounced level
// and one-cycle rise/fall/hold pulses, all timed on a shared prescaled tick.
module debounce_array #(
    parameter int N_CH           = 4,
    parameter int CLK_PERIOD_NS  = 5,
    parameter int TICK_US        = 100,
    parameter int DEBOUNCE_TICKS = 50,
    parameter int HOLD_TICKS     = 10000,
    parameter logic [N_CH-1:0] INVERT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] dirty,
    output logic [N_CH-1:0] clean,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] hold
);

    localparam int TICK_CYCLES = (TICK_US * 1000 + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam bit HOLD_EN = (HOLD_TICKS > 0);

    localparam logic [PW-1:0] P_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] H_LAST = HW'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

    logic [N_CH-1:0] pol_in;
    logic [N_CH-1:0] s1;
    logic [N_CH-1:0] s2;
    logic [N_CH-1:0] prev;
    logic [PW-1:0]   pcnt;
    logic            tick;
    logic [DW-1:0]   dcnt [N_CH];
    logic [HW-1:0]   hcnt [N_CH];
    logic [N_CH-1:0] commit;
    logic [N_CH-1:0] hold_hit;

    assign pol_in = dirty ^ INVERT;
    assign tick   = (pcnt == P_LAST);

    // commit never coincides with hold_hit: a falling commit suppresses the hold
    always_comb begin
        commit   = '0;
        hold_hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            commit[i]   = (s2[i] == prev[i]) && (s2[i] != clean[i]) && tick
                          && (dcnt[i] == D_LAST);
            hold_hit[i] = HOLD_EN && clean[i] && !commit[i] && tick
                          && (hcnt[i] == H_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= pol_in;
            s2    <= pol_in;
            prev  <= pol_in;
            clean <= pol_in;
            pcnt  <= '0;
            rise  <= '0;
            fall  <= '0;
            hold  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                dcnt[i] <= '0;
                hcnt[i] <= '0;
            end
        end else begin
            s1   <= pol_in;
            s2   <= s1;
            prev <= s2;
            pcnt <= tick ? '0 : pcnt + PW'(1);
            rise <= '0;
            fall <= '0;
            hold <= hold_hit;
            for (int i = 0; i < N_CH; i++) begin
                if ((s2[i] != prev[i]) || (s2[i] == clean[i])) begin
                    dcnt[i] <= '0;
                end else if (tick) begin
                    if (commit[i]) begin
                        clean[i] <= s2[i];
                        dcnt[i]  <= '0;
                        rise[i]  <= s2[i];
                        fall[i]  <= ~s2[i];
                    end else begin
                        dcnt[i] <= dcnt[i] + DW'(1);
                    end
                end

                if (!clean[i] || commit[i]) begin
                    hcnt[i] <= '0;
                end else if (HOLD_EN && tick && (hcnt[i] != H_MAX)) begin
                    hcnt[i] <= hcnt[i] + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_debounce_array.sv
// Scoreboard bench for debounce_array: two instances (plain and ch1-inverted) share one
// monitor that pops expected pulses with their allowed cycle windows.
module tb_debounce_array;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [1:0] dirty_a, dirty_b;
    logic [1:0] clean_a, rise_a, fall_a, hold_a;
    logic [1:0] clean_b, rise_b, fall_b, hold_b;

    always #5 clk = ~clk;

    debounce_array #(.N_CH(2), .CLK_PERIOD_NS(10), .TICK_US(1), .DEBOUNCE_TICKS(4),
                     .HOLD_TICKS(20), .INVERT(2'b00)) dut_a (
        .clk(clk), .rst(rst_a), .dirty(dirty_a), .clean(clean_a),
        .rise(rise_a), .fall(fall_a), .hold(hold_a));

    debounce_array #(.N_CH(2), .CLK_PERIOD_NS(10), .TICK_US(1), .DEBOUNCE_TICKS(4),
                     .HOLD_TICKS(20), .INVERT(2'b10)) dut_b (
        .clk(clk), .rst(rst_b), .dirty(dirty_b), .clean(clean_b),
        .rise(rise_b), .fall(fall_b), .hold(hold_b));

    typedef struct {
        int kind;   // 0 rise, 1 fall, 2 hold
        int ch;     // 0..1 dut_a, 2..3 dut_b
        int t0;
        int lo;
        int hi;
        bit rel;    // window measured from the channel's last rise
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   last_rise [4];

    logic [3:0] rise_all, fall_all, hold_all, clean_all;
    assign rise_all  = {rise_b, rise_a};
    assign fall_all  = {fall_b, fall_a};
    assign hold_all  = {hold_b, hold_a};
    assign clean_all = {clean_b, clean_a};

    always @(posedge clk) cyc <= cyc + 1;

    exp_t e;
    int   base, dt;
    bit   pulse, lvl_ok;

    always @(negedge clk) begin
        for (int ch = 0; ch < 4; ch++) begin
            for (int k = 0; k < 3; k++) begin
                pulse = (k == 0) ? rise_all[ch] : (k == 1) ? fall_all[ch] : hold_all[ch];
                if (pulse) begin
                    vectors++;
                    if (sbq.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_pulse: kind %0d ch %0d at cycle %0d, required none",
                                 k, ch, cyc);
                    end else begin
                        e      = sbq.pop_front();
                        base   = e.rel ? last_rise[e.ch] : e.t0;
                        dt     = cyc - base;
                        lvl_ok = (k == 2) ? (clean_all[ch] == 1'b1) : (clean_all[ch] == (k == 0));
                        if (e.kind != k || e.ch != ch || dt < e.lo || dt > e.hi || !lvl_ok) begin
                            miscompares++;
                            $display("FAIL pulse: got kind %0d ch %0d dt %0d clean %0b, required kind %0d ch %0d dt %0d..%0d",
                                     k, ch, dt, clean_all[ch], e.kind, e.ch, e.lo, e.hi);
                        end
                    end
                    if (k == 0) last_rise[ch] = cyc;
                end
            end
        end
    end

    task automatic push(input int kind, input int ch, input int lo, input int hi, input bit rel);
        exp_t x;
        x.kind = kind; x.ch = ch; x.t0 = cyc + 1; x.lo = lo; x.hi = hi; x.rel = rel;
        sbq.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        dirty_a = 2'b01;
        dirty_b = 2'b00;
        rst_a   = 1'b1;
        rst_b   = 1'b1;
        wait_cyc(5);
        check("rst_clean_held", int'(clean_a), 1);
        check("rst_pulses_held", int'({rise_a, fall_a, hold_a}), 0);
        rst_a = 1'b0;
        wait_cyc(1);
        check("rst_clean_released", int'(clean_a), 1);
        wait_cyc(1000);
        check("rst_quiet_queue", sbq.size(), 0);

        // release ch0 so the clean press starts from 0
        dirty_a[0] = 1'b0;
        push(1, 0, 303, 402, 0);
        wait_cyc(500);
        check("release_clean", int'(clean_a), 0);

        dirty_a[0] = 1'b1;
        push(0, 0, 303, 402, 0);
        wait_cyc(500);
        check("press_clean", int'(clean_a), 1);
        check("press_queue", sbq.size(), 0);

        dirty_a[0] = 1'b0;
        push(1, 0, 303, 402, 0);
        wait_cyc(500);

        // 21 edges 50 cycles apart, ending high
        for (int i = 0; i < 21; i++) begin
            if (i == 20) check("bounce_clean_mid", int'(clean_a[0]), 0);
            dirty_a[0] = ~dirty_a[0];
            if (i < 20) wait_cyc(50);
        end
        push(0, 0, 303, 402, 0);
        wait_cyc(500);
        check("bounce_clean_after", int'(clean_a[0]), 1);
        dirty_a[0] = 1'b0;
        push(1, 0, 303, 402, 0);
        wait_cyc(500);

        dirty_a[0] = 1'b1;
        wait_cyc(250);
        dirty_a[0] = 1'b0;
        wait_cyc(600);
        check("glitch_clean", int'(clean_a[0]), 0);
        check("glitch_queue", sbq.size(), 0);

        dirty_a[0] = 1'b1;
        push(0, 0, 303, 402, 0);
        push(2, 0, 1900, 2100, 1);
        wait_cyc(3000);
        check("long_clean", int'(clean_a[0]), 1);
        dirty_a[0] = 1'b0;
        push(1, 0, 303, 402, 0);
        wait_cyc(500);

        dirty_a[0] = 1'b1;
        push(0, 0, 303, 402, 0);
        wait_cyc(1000);
        dirty_a[0] = 1'b0;
        push(1, 0, 303, 402, 0);
        wait_cyc(500);
        check("second_press_queue", sbq.size(), 0);
        check("ch1_untouched", int'(clean_a[1]), 0);

        // inverted instance, with a reset landing mid-count on ch0
        rst_b = 1'b0;
        wait_cyc(1);
        check("inv_clean_after_rst", int'(clean_b), 2);
        wait_cyc(10);
        dirty_b[0] = 1'b1;
        wait_cyc(200);
        rst_b = 1'b1;
        wait_cyc(1);
        check("inv_midcount_rst_clean", int'(clean_b), 3);
        check("inv_midcount_rst_pulses", int'({rise_b, fall_b, hold_b}), 0);
        wait_cyc(4);
        rst_b = 1'b0;
        push(2, 2, 1900, 2100, 0);
        push(2, 3, 1900, 2100, 0);
        wait_cyc(2300);
        check("inv_final_clean", int'(clean_b), 3);
        check("final_queue", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/debounce_array.md
Name: debounce_array

Overview:
- Multi-channel successor to the single-input debouncer, for front-panel buttons and switches feeding the control FSMs.
- Each channel has a 2-flop synchroniser, optional polarity inversion, and a debounced level.
- Each channel also produces one-cycle rise, fall and long-press (hold) pulses.
- Timing counts a shared prescaled tick instead of raw clocks, so per-channel counters stay narrow.

Parameters:
N_CH, 4, number of independent channels
CLK_PERIOD_NS, 5, clk period in ns
TICK_US, 100, shared tick period in µs; TICK_CYCLES = ceil(TICK_US*1000/CLK_PERIOD_NS), must be >= 1
DEBOUNCE_TICKS, 50, ticks an input must stay stable before clean changes; must be >= 1
HOLD_TICKS, 10000, ticks clean must stay 1 before hold fires; 0 disables hold
INVERT, {N_CH{1'b0}}, per-channel bitmask; a 1 inverts that raw input (active-low buttons)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
dirty  input  N_CH  raw asynchronous inputs
clean  output  N_CH  debounced, inverted-as-configured levels
rise  output  N_CH  one-cycle pulse when clean goes 0->1
fall  output  N_CH  one-cycle pulse when clean goes 1->0
hold  output  N_CH  one-cycle pulse once per press after HOLD_TICKS

Behaviour:
- Definition: in = dirty ^ INVERT. Sync path: s1 <= in, s2 <= s1. prev <= s2 every cycle.
- Reset (rst=1, any cycle, including mid-count):
  - s1, s2, prev and clean load in directly.
  - Prescaler, all debounce counters and all hold counters go to 0.
  - rise, fall and hold are 0.
  - No pulse fires on the first cycle after rst deasserts.
- Prescaler:
  - Counts 0..TICK_CYCLES-1, then wraps to 0.
  - tick=1 for exactly one cycle when count==TICK_CYCLES-1.
  - Shared by all channels; free-running while rst=0.
- Per-channel debounce (priority order):
  1. s2 != prev: dcnt <= 0. A change wins over a coincident tick; that tick is not counted.
  2. Else if s2 == clean: dcnt <= 0.
  3. Else if tick:
     - If dcnt == DEBOUNCE_TICKS-1: clean <= s2, dcnt <= 0, and rise or fall <= 1 in the same cycle.
     - Otherwise dcnt <= dcnt+1.
- Counter widths:
  - dcnt is $clog2(DEBOUNCE_TICKS+1) bits.
  - hcnt is $clog2(HOLD_TICKS+1) bits.
  - No wrap is possible; dcnt never exceeds DEBOUNCE_TICKS-1.
- Latency:
  - Stable raw change to s2: 2 cycles.
  - s2 change to clean update: between (DEBOUNCE_TICKS-1)*TICK_CYCLES+1 and DEBOUNCE_TICKS*TICK_CYCLES cycles. The jitter is tick phase.
- Pulses:
  - rise, fall and hold are registered, width exactly 1 cycle.
  - Each deasserts next cycle unless re-triggered.
  - rise or fall is high in the first cycle clean shows the new value.
- Hold (HOLD_TICKS>0):
  - While clean==1, hcnt increments on tick.
  - When hcnt reaches HOLD_TICKS on a tick, hold <= 1 for one cycle. hcnt then saturates at HOLD_TICKS, so there is no repeat.
  - clean==0 clears hcnt to 0.
  - A press shorter than HOLD_TICKS gives no hold.
  - hold and fall can never coincide.
  - With HOLD_TICKS=0, hold stays 0.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Glitch shorter than the debounce time: dcnt restarts on each toggle, so clean is unchanged.
- Input that bounces back to the clean value before commit: rule 2 clears dcnt, no pulse.

Test Plan (N_CH=2, CLK_PERIOD_NS=10, TICK_US=1 -> TICK_CYCLES=100, DEBOUNCE_TICKS=4, HOLD_TICKS=20, INVERT=2'b00 unless stated):
- Reset: dirty=2'b01, assert rst 5 cycles, release -> clean=2'b01 immediately; rise/fall/hold stay 0 for 1000 cycles.
- Clean press ch0: dirty[0] 0->1 and held -> clean[0]=1 within 303..402 cycles of the input edge, rise[0] high exactly 1 cycle in that same cycle; clean[1], rise[1], fall[1] stay 0.
- Bounce: dirty[0] toggles every 50 cycles for 1000 cycles, then stays 1 -> no clean change during the bounce; exactly one rise[0] 303..402 cycles after the last edge; no fall[0].
- Short glitch: dirty[0]=1 for 250 cycles, then 0 -> clean[0] stays 0; no rise[0] or fall[0].
- Long press: dirty[0]=1 held for 3000 cycles, then released -> one rise[0]; one hold[0] pulse 2000 cycles (20 ticks, ±1 tick) after clean[0] rises and none after; one fall[0] after release; second press of 1000 cycles gives no hold[0].
- Inversion + mid-count reset: INVERT=2'b10, dirty=2'b00 -> clean[1]=1 after rst. Then dirty[0]=1, assert rst 200 cycles later -> clean[0]=1 immediately, dcnt cleared, no rise[0] at any point.
